// File: rtl/debounce_edge_detect.sv
// Debouncer: 2-flop synchroniser, stability FSM, registered level/complement and edge pulses.
// Output level changes STABLE_CYCLES+1 edges after the raw input settles at the new level.
module debounce_edge_detect #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       d_in,
  output logic       q,
  output logic       qbar,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [1:0] state_o
);

  localparam logic [1:0] LOW      = 2'd0;
  localparam logic [1:0] CHK_HIGH = 2'd1;
  localparam logic [1:0] HIGH     = 2'd2;
  localparam logic [1:0] CHK_LOW  = 2'd3;

  // Compare against STABLE_CYCLES-1 so that STABLE_CYCLES == 2**CNT_W still fits the counter.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             lvlb_q, lvlb_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    lvlb_d  = lvlb_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (s2_q) begin
          state_d = CHK_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      CHK_HIGH: begin
        if (!s2_q) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          lvl_d   = 1'b1;
          lvlb_d  = 1'b0;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!s2_q) begin
          state_d = CHK_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        if (s2_q) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          lvl_d   = 1'b0;
          lvlb_d  = 1'b1;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      lvlb_q  <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= d_in;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      lvlb_q  <= lvlb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q          = lvl_q;
  assign qbar       = lvlb_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: run-length reference model feeds an expectation queue,
// plus directed latency / glitch / reset checks.
module tb_debounce_edge_detect;

  localparam int SC = 4;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       d_in  = 1'b0;
  logic       q, qbar, rise_pulse, fall_pulse;
  logic [1:0] state_o;

  debounce_edge_detect #(.STABLE_CYCLES(SC), .CNT_W(4)) dut (
    .clock      (clock),
    .clear      (clear),
    .d_in       (d_in),
    .q          (q),
    .qbar       (qbar),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .state_o    (state_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       q;
    logic       qbar;
    logic       rise;
    logic       fall;
    logic [1:0] st;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   rise_cnt = 0, fall_cnt = 0;
  int   rise_edge = -1, fall_edge = -1;

  // Reference: q flips once s2 has disagreed with q for SC consecutive samples.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_q = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int   m_run = 0;

  task automatic model_push(input logic d, input logic clr);
    obs_t e;
    logic old_s2;
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_q = 0; m_rise = 0; m_fall = 0; m_run = 0;
    end else begin
      old_s2 = m_s2;
      m_s2 = m_s1;
      m_s1 = d;
      m_rise = 0;
      m_fall = 0;
      if (old_s2 != m_q) begin
        m_run++;
        if (m_run == SC) begin
          m_q = ~m_q;
          m_rise = m_q;
          m_fall = ~m_q;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    e.q = m_q;
    e.qbar = ~m_q;
    e.rise = m_rise;
    e.fall = m_fall;
    e.st = m_q ? ((m_run != 0) ? 2'd3 : 2'd2) : ((m_run != 0) ? 2'd1 : 2'd0);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic d, input logic clr);
    obs_t e, o;
    d_in = d;
    clear = clr;
    model_push(d, clr);
    @(posedge clock);
    edge_n++;
    #1;
    e = exp_q.pop_front();
    o = {q, qbar, rise_pulse, fall_pulse, state_o};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL cycle edge=%0d observed={q,qbar,rise,fall,st}=%b expected=%b", edge_n, o, e);
    end
    if (rise_pulse === 1'b1) begin rise_cnt++; rise_edge = edge_n; end
    if (fall_pulse === 1'b1) begin fall_cnt++; fall_edge = edge_n; end
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b0);
  endtask

  initial begin
    int e0, rc, fc;
    logic [9:0] bounce;

    // Reset held while input toggles
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_q", int'(q), 0);
    chk("reset_qbar", int'(qbar), 1);
    chk("reset_state", int'(state_o), 0);
    hold(1'b0, 10);
    chk("idle_low_q", int'(q), 0);

    // Clean rise
    e0 = edge_n + 1;
    rc = rise_cnt;
    hold(1'b1, 10);
    chk("rise_edge", rise_edge, e0 + SC + 1);
    chk("rise_count", rise_cnt, rc + 1);
    chk("rise_qbar", int'(qbar), 0);

    // Clean fall
    e0 = edge_n + 1;
    fc = fall_cnt;
    hold(1'b0, 10);
    chk("fall_edge", fall_edge, e0 + SC + 1);
    chk("fall_count", fall_cnt, fc + 1);

    // Three-cycle glitch rejected
    rc = rise_cnt;
    hold(1'b1, 3);
    hold(1'b0, 8);
    chk("glitch3_rise", rise_cnt, rc);
    chk("glitch3_state", int'(state_o), 0);

    // Four-cycle excursion accepted
    hold(1'b1, 4);
    hold(1'b0, 12);
    chk("glitch4_rise", rise_cnt, rc + 1);
    chk("glitch4_back_low", int'(q), 0);

    // Bounce 1,0,1,1,0,1,1,1,1,1 then held high
    bounce = 10'b1111101101;
    rc = rise_cnt;
    e0 = edge_n + 6;
    for (int i = 0; i < 10; i++) step(bounce[i], 1'b0);
    hold(1'b1, 6);
    chk("bounce_rise_count", rise_cnt, rc + 1);
    chk("bounce_rise_edge", rise_edge, e0 + SC + 1);

    // Fall with 0,0,1 bounce restarting the count
    fc = fall_cnt;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    e0 = edge_n + 1;
    hold(1'b0, 10);
    chk("bounce_fall_count", fall_cnt, fc + 1);
    chk("bounce_fall_edge", fall_edge, e0 + SC + 1);

    // Clear during CHK_HIGH with count at 2
    rc = rise_cnt;
    hold(1'b1, 4);
    chk("pre_clear_state", int'(state_o), 1);
    step(1'b1, 1'b1);
    chk("clear_chk_state", int'(state_o), 0);
    chk("clear_chk_q", int'(q), 0);
    chk("clear_chk_rise", rise_cnt, rc);

    // Refill after clear with input held high
    e0 = edge_n + 1;
    hold(1'b1, 10);
    chk("refill_rise_edge", rise_edge, e0 + SC + 1);

    // Clear while high
    fc = fall_cnt;
    step(1'b1, 1'b1);
    chk("clear_high_q", int'(q), 0);
    chk("clear_high_qbar", int'(qbar), 1);
    chk("clear_high_fall", fall_cnt, fc);
    hold(1'b0, 8);
    chk("post_clear_low", int'(q), 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
